// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for an RV32I subset (addi, lw, sw, bne): sequences one shared
// memory and one ALU across instruction phases and drives every datapath enable/mux.
module multicycle_ctrl #(
  parameter int Wid = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [Wid-1:0] instr,
  input  logic           EQ,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           Data_WE,
  output logic           AdrSrc,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           PCsrc,
  output logic           RegWrite,
  output logic           ResultSrc,
  output logic           ALUsrc,
  output logic [2:0]     ALUctrl,
  output logic [1:0]     ImmSrc,
  output logic           retire,
  output logic [Wid-1:0] instr_cnt,
  output logic           trap,
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEMADR = 3'd4,
    MEMACC = 3'd5,
    WB     = 3'd6,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  state_t         state_q, state_d;
  logic [Wid-1:0] instr_cnt_q, instr_cnt_d;
  logic           trap_q, trap_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_bne, is_lw, is_sw;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign is_bne       = (opcode == OP_BRANCH);
  assign is_lw        = (opcode == OP_LOAD);
  assign is_sw        = (opcode == OP_STORE);
  assign unused_instr = ^{instr[Wid-1:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_cnt_q <= '0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      trap_q      <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    Data_WE   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b000;
    ImmSrc    = 2'b00;
    retire    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        unique case (opcode)
          OP_IMM, OP_BRANCH: state_d = EXEC;
          OP_LOAD, OP_STORE: state_d = MEMADR;
          default:           state_d = TRAP;
        endcase
      end
      EXEC: begin
        // bne resolves here: the ALU compares rs1/rs2 while the target old_pc+imm is selected
        ALUctrl = funct3;
        if (is_bne) begin
          ImmSrc  = 2'b10;
          PCsrc   = ~EQ;
          PCWrite = ~EQ;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          ALUsrc  = 1'b1;
          state_d = WB;
        end
      end
      MEMADR: begin
        ALUsrc  = 1'b1;
        ImmSrc  = is_sw ? 2'b01 : 2'b00;
        state_d = MEMACC;
      end
      MEMACC: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        Data_WE = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_lw;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      TRAP: state_d = TRAP;
    endcase
  end

  assign instr_cnt_d = retire ? instr_cnt_q + Wid'(1) : instr_cnt_q;
  assign trap_d      = trap_q | (state_d == TRAP);

  assign instr_cnt = instr_cnt_q;
  assign trap      = trap_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: one record per clock cycle with hand-computed
// expected outputs, plus hand-written asynchronous-reset sequences.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ready;
  logic        mem_req, Data_WE, AdrSrc, IRWrite, PCWrite, PCsrc;
  logic        RegWrite, ResultSrc, ALUsrc, retire, trap;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc;
  logic [31:0] instr_cnt;
  logic [2:0]  state_o;

  multicycle_ctrl #(.Wid(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .Data_WE(Data_WE), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .retire(retire),
    .instr_cnt(instr_cnt), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        eq;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [31:0] cnt;
    logic        trap;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  // ctl = {mem_req, Data_WE, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc, ALUsrc, ALUctrl, ImmSrc, retire}
  function automatic logic [14:0] pack(input logic mr, we, adr, irw, pcw, pcs, rw, rs, as,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic ret);
    return {mr, we, adr, irw, pcw, pcs, rw, rs, as, alu, imm, ret};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic e, input logic r,
                              input logic [2:0] s, input logic [14:0] c,
                              input logic [31:0] n, input logic t);
    vec_t v;
    v.instr = i; v.eq = e; v.rdy = r; v.st = s; v.ctl = c; v.cnt = n; v.trap = t;
    return v;
  endfunction

  task automatic check(input vec_t v, input string tag);
    logic [14:0] act;
    act = pack(mem_req, Data_WE, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
               ALUsrc, ALUctrl, ImmSrc, retire);
    n_vec++;
    if (act !== v.ctl || state_o !== v.st || instr_cnt !== v.cnt || trap !== v.trap) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b st=%0d cnt=%0d trap=%b, want ctl=%b st=%0d cnt=%0d trap=%b",
               tag, act, state_o, instr_cnt, trap, v.ctl, v.st, v.cnt, v.trap);
    end
  endtask

  task automatic drive(input vec_t v);
    instr     = v.instr;
    EQ        = v.eq;
    mem_ready = v.rdy;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check(v, tag);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0080_A103;
  localparam logic [31:0] I_SW   = 32'h0020_A223;
  localparam logic [31:0] I_BNE  = 32'hFE20_9EE3;
  localparam logic [31:0] I_ILL  = 32'h0000_0033;

  initial begin
    logic [14:0] Z, FW, FR, EA, WBA, MAL, MAS, MCL, MCSR, WBL, BN0, BN1;
    Z    = '0;
    FW   = pack(1,0,0,0,0,0,0,0,0,3'b000,2'b00,0);
    FR   = pack(1,0,0,1,1,0,0,0,0,3'b000,2'b00,0);
    EA   = pack(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0);
    WBA  = pack(0,0,0,0,0,0,1,0,0,3'b000,2'b00,1);
    MAL  = pack(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0);
    MAS  = pack(0,0,0,0,0,0,0,0,1,3'b000,2'b01,0);
    MCL  = pack(1,0,1,0,0,0,0,0,0,3'b000,2'b00,0);
    MCSR = pack(1,1,1,0,0,0,0,0,0,3'b000,2'b00,1);
    WBL  = pack(0,0,0,0,0,0,1,1,0,3'b000,2'b00,1);
    BN0  = pack(0,0,0,0,1,1,0,0,0,3'b001,2'b10,1);
    BN1  = pack(0,0,0,0,0,0,0,0,0,3'b001,2'b10,1);

    // addi: IDLE, FETCH, DECODE, EXEC, WB
    vecs.push_back(mk(I_ADDI,0,1,3'd0,Z,0,0));
    vecs.push_back(mk(I_ADDI,0,1,3'd1,FR,0,0));
    vecs.push_back(mk(I_ADDI,0,1,3'd2,Z,0,0));
    vecs.push_back(mk(I_ADDI,0,1,3'd3,EA,0,0));
    vecs.push_back(mk(I_ADDI,0,1,3'd6,WBA,0,0));
    // lw with three MEMACC wait cycles: 8 cycles total
    vecs.push_back(mk(I_LW,0,1,3'd1,FR,1,0));
    vecs.push_back(mk(I_LW,0,1,3'd2,Z,1,0));
    vecs.push_back(mk(I_LW,0,1,3'd4,MAL,1,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(I_LW,0,0,3'd5,MCL,1,0));
    vecs.push_back(mk(I_LW,0,1,3'd5,MCL,1,0));
    vecs.push_back(mk(I_LW,0,1,3'd6,WBL,1,0));
    // sw with one FETCH wait cycle
    vecs.push_back(mk(I_SW,0,0,3'd1,FW,2,0));
    vecs.push_back(mk(I_SW,0,1,3'd1,FR,2,0));
    vecs.push_back(mk(I_SW,0,1,3'd2,Z,2,0));
    vecs.push_back(mk(I_SW,0,1,3'd4,MAS,2,0));
    vecs.push_back(mk(I_SW,0,1,3'd5,MCSR,2,0));
    // bne taken (EQ=0) then not taken (EQ=1)
    vecs.push_back(mk(I_BNE,0,1,3'd1,FR,3,0));
    vecs.push_back(mk(I_BNE,0,1,3'd2,Z,3,0));
    vecs.push_back(mk(I_BNE,0,1,3'd3,BN0,3,0));
    vecs.push_back(mk(I_BNE,1,1,3'd1,FR,4,0));
    vecs.push_back(mk(I_BNE,1,1,3'd2,Z,4,0));
    vecs.push_back(mk(I_BNE,1,1,3'd3,BN1,4,0));
    // illegal opcode: TRAP is terminal, mem_ready ignored
    vecs.push_back(mk(I_ILL,0,1,3'd1,FR,5,0));
    vecs.push_back(mk(I_ILL,0,1,3'd2,Z,5,0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(I_ILL,0,1,3'd7,Z,5,1));

    // reset held: all outputs zero
    rst_n = 1'b0;
    drive(mk(I_ADDI,0,1,3'd0,Z,0,0));
    @(posedge clk);
    @(negedge clk);
    check(mk(I_ADDI,0,1,3'd0,Z,0,0), "reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset out of TRAP clears trap and count at once
    rst_n = 1'b0;
    #1 check(mk(I_ILL,0,1,3'd0,Z,0,0), "reset_from_trap");
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk(I_ADDI,0,1,3'd0,Z,0,0), "re_idle");
    apply(mk(I_ADDI,0,1,3'd1,FR,0,0), "re_fetch");
    apply(mk(I_ADDI,0,1,3'd2,Z,0,0), "re_decode");
    apply(mk(I_ADDI,0,1,3'd3,EA,0,0), "re_exec");
    apply(mk(I_ADDI,0,1,3'd6,WBA,0,0), "re_wb");

    // reset mid-FETCH: mem_req must drop without waiting for a clock edge
    drive(mk(I_ADDI,0,0,3'd1,FW,1,0));
    @(negedge clk);
    check(mk(I_ADDI,0,0,3'd1,FW,1,0), "fetch_wait");
    #1 rst_n = 1'b0;
    #1 check(mk(I_ADDI,0,0,3'd0,Z,0,0), "reset_mid_fetch");
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk(I_ADDI,0,1,3'd0,Z,0,0), "post_idle");
    apply(mk(I_ADDI,0,1,3'd1,FR,0,0), "post_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I subset datapath: addi, lw, sw, bne.
- Replaces single-cycle decode, so one shared instruction/data memory with a ready handshake and one ALU are time-multiplexed across instruction phases.
- Drives all datapath enables and muxes from a state machine.
- Keeps a retired-instruction counter and a sticky illegal-opcode trap.

Parameters:
- Wid, 32, instruction width and retired-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  Wid  current IR contents; valid from DECODE onward.
- EQ  in  1  ALU zero/equal flag; sampled in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- Data_WE  out  1  memory write enable; qualifies mem_req.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IRWrite  out  1  load IR and old_pc from the memory read data / PC.
- PCWrite  out  1  PC register enable.
- PCsrc  out  1  PC next: 0 = PC+4, 1 = old_pc+imm.
- RegWrite  out  1  register file write.
- ResultSrc  out  1  writeback select: 0 = ALU result, 1 = memory data.
- ALUsrc  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- ALUctrl  out  3  ALU operation.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_cnt  out  Wid  retired-instruction count.
- trap  out  1  sticky illegal-opcode flag.
- state_o  out  3  current state, for debug.

Behaviour:
- States and encodings:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - EXEC = 3
  - MEMADR = 4
  - MEMACC = 5
  - WB = 6
  - TRAP = 7
  - BRANCH is folded into EXEC for the bne opcode.
- Reset (rst_n low, asynchronous): state = IDLE, instr_cnt = 0, trap = 0.
  - All outputs are decoded from state, so every output is 0 while in IDLE.
  - IDLE -> FETCH unconditionally on the first clk edge after reset release.
- FETCH:
  - Drives mem_req = 1, AdrSrc = 0, Data_WE = 0.
  - Holds in FETCH while mem_ready = 0.
  - On mem_ready = 1: IRWrite = 1, PCWrite = 1, PCsrc = 0, then -> DECODE.
  - IRWrite and PCWrite are 0 in every other FETCH cycle.
- DECODE: no enables asserted. Next state by opcode = instr[6:0]:
  - 0010011 -> EXEC
  - 1100011 -> EXEC
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - anything else -> TRAP
- EXEC, addi: ALUsrc = 1, ImmSrc = 00, ALUctrl = instr[14:12]; -> WB.
- EXEC, bne: ALUsrc = 0, ImmSrc = 10, ALUctrl = instr[14:12].
  - PCsrc = ~EQ, PCWrite = ~EQ.
  - retire = 1; -> FETCH. Total 3 cycles without memory wait.
- MEMADR: ALUsrc = 1, ALUctrl = 000.
  - ImmSrc = 00 for lw, 01 for sw.
  - ALU result is latched by the datapath; -> MEMACC.
- MEMACC: mem_req = 1, AdrSrc = 1, Data_WE = 1 for sw only.
  - Waits on mem_ready.
  - On ready: lw -> WB; sw -> FETCH with retire = 1.
- WB: RegWrite = 1, retire = 1; -> FETCH.
  - ResultSrc = 1 for lw, 0 for addi.
- Minimum cycle counts with zero memory wait:
  - addi 4, lw 5, sw 4, bne 3.
  - Each memory wait cycle adds 1.
- TRAP: trap = 1. Terminal: exits only via reset. No enables, no mem_req, no retire.
- instr_cnt increments by 1 on every cycle where retire = 1, wrapping modulo 2^Wid.
- mem_req stays high and its address/Data_WE stay stable until mem_ready. mem_ready while mem_req = 0 is ignored.
- Reset asserted mid-access drops mem_req asynchronously. No partial IR/PC/register write occurs.
- Unlisted outputs in any state are 0. No latches: every output has a default.

Test Plan:
- Reset, then release, mem_ready tied 1 -> one IDLE cycle. FETCH asserts mem_req = 1, AdrSrc = 0, IRWrite = 1, PCWrite = 1 in the same cycle. All outputs 0 during reset.
- addi x1,x0,5 (0x00500093), zero wait -> FETCH, DECODE, EXEC, WB. In EXEC: ALUsrc = 1, ALUctrl = 000. RegWrite = 1 only in WB, ResultSrc = 0. instr_cnt 0 -> 1.
- lw with mem_ready low 3 cycles in MEMACC -> mem_req, AdrSrc = 1 held 4 cycles. Total 8 cycles. WB has ResultSrc = 1, RegWrite = 1.
- sw (opcode 0100011) -> ImmSrc = 01 in MEMADR. Data_WE = 1 with mem_req in MEMACC. No RegWrite. retire on the MEMACC ready cycle.
- bne (0xFE209EE3):
  - EQ = 0 -> PCWrite = 1, PCsrc = 1 in EXEC.
  - EQ = 1 -> PCWrite = 0.
  - Both cases: 3 cycles, retire pulse.
- Opcode 0110011 -> DECODE -> TRAP. trap = 1 and held over 10 cycles, no mem_req. Reset pulse mid-FETCH clears trap and instr_cnt; mem_req drops immediately.
